// File: rtl/pattern_pkg.sv
// Shared types and helpers for the training-pattern sequencer.
package pattern_pkg;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_e;

    // Galois feedback mask for taps 16,14,13,11 (right-shifting form)
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    function automatic logic [15:0] lfsr_next(input logic [15:0] v);
        lfsr_next = v[0] ? ((v >> 1) ^ LFSR_TAPS) : (v >> 1);
    endfunction

    // lr - (lr >> shift), floored at lr_min; callers truncate to their word width
    function automatic logic [31:0] lr_decay(input logic [31:0] lr,
                                             input int unsigned shift,
                                             input logic [31:0] lr_min);
        logic [31:0] dec;
        dec      = lr - (lr >> shift);
        lr_decay = (dec < lr_min) ? lr_min : dec;
    endfunction

endpackage

// File: rtl/pattern_mem.sv
// Sample store: single write port, single read port with a registered, resettable read
// register. A same-address write and read in one cycle returns the old word.
module pattern_mem #(
    parameter int unsigned DEPTH = 12,
    parameter int unsigned WIDTH = 80,
    parameter int unsigned AW    = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en && (32'(wr_addr) < DEPTH)) begin
            mem[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/pattern_sequencer.sv
// Training/validation sample sequencer with epoch tracking and lr decay.
// Optional per-epoch training-order rotation via LFSR when PATTERN_SHUFFLE_EN is defined.
module pattern_sequencer
    import pattern_pkg::*;
#(
    parameter int unsigned     NX        = 4,
    parameter int unsigned     BITS      = 16,
    parameter int unsigned     NTRAIN    = 8,
    parameter int unsigned     NVALID    = 4,
    parameter int unsigned     EPOCH_MAX = 16,
    parameter logic [BITS-1:0] LR_INIT   = BITS'(16'h1000),
    parameter int unsigned     LR_SHIFT  = 3,
    parameter logic [BITS-1:0] LR_MIN    = BITS'(16'h0040),
    parameter logic [15:0]     SEED      = 16'hACE1
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 sw,
    input  logic                                 tr,
    input  logic                                 vl,
    input  logic                                 ld_en,
    input  logic [$clog2(NTRAIN+NVALID)-1:0]     ld_addr,
    input  logic [NX*BITS-1:0]                   ld_x,
    input  logic [BITS-1:0]                      ld_y,
    output logic [NX*BITS-1:0]                   x,
    output logic [BITS-1:0]                      y,
    output logic                                 out_valid,
    output logic                                 is_train,
    output logic                                 vl_drop,
    output logic [BITS-1:0]                      lr,
    output logic [BITS-1:0]                      TRAIN,
    output logic [BITS-1:0]                      VALID,
    output logic [BITS-1:0]                      EPOCH,
    output logic                                 done
);

    localparam int unsigned AW = $clog2(NTRAIN + NVALID);
    localparam int unsigned TW = (NTRAIN > 1) ? $clog2(NTRAIN) : 1;
    localparam int unsigned VW = (NVALID > 1) ? $clog2(NVALID) : 1;
    localparam int unsigned MW = NX * BITS + BITS;

    state_e          state_q, state_d;
    logic [TW-1:0]   tptr_q, tptr_d;
    logic [VW-1:0]   vptr_q, vptr_d;
    logic [BITS-1:0] train_q, train_d;
    logic [BITS-1:0] valid_q, valid_d;
    logic [BITS-1:0] epoch_q, epoch_d;
    logic [BITS-1:0] lr_q, lr_d;
    logic            out_valid_q, out_valid_d;
    logic            is_train_q, is_train_d;
    logic            vl_drop_q, vl_drop_d;

    logic            tr_acc, vl_acc, epoch_end;
    logic            rd_en;
    logic [AW-1:0]   rd_addr;
    logic [TW:0]     tsum;
    logic [BITS-1:0] epoch_inc;
    logic [TW-1:0]   offset;
    logic [MW-1:0]   rd_data;

`ifdef PATTERN_SHUFFLE_EN
    logic [15:0]   lfsr_q, lfsr_d;
    logic [TW-1:0] offset_q, offset_d;
    logic [TW:0]   step, osum;

    assign offset = offset_q;

    always_comb begin
        lfsr_d   = lfsr_q;
        offset_d = offset_q;
        step     = {1'b0, lfsr_q[TW-1:0]};
        if (32'(step) >= NTRAIN) step = step - (TW+1)'(NTRAIN);
        osum = {1'b0, offset_q} + step;
        if (32'(osum) >= NTRAIN) osum = osum - (TW+1)'(NTRAIN);
        if (sw) begin
            lfsr_d   = SEED;
            offset_d = '0;
        end else if (epoch_end) begin
            // Rotation for the next epoch uses the LFSR value held during this one
            lfsr_d   = lfsr_next(lfsr_q);
            offset_d = osum[TW-1:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr_q   <= SEED;
            offset_q <= '0;
        end else begin
            lfsr_q   <= lfsr_d;
            offset_q <= offset_d;
        end
    end
`else
    logic unused_seed;
    assign unused_seed = ^SEED;
    assign offset      = '0;
`endif

    assign epoch_inc = epoch_q + BITS'(1);

    always_comb begin
        state_d     = state_q;
        tptr_d      = tptr_q;
        vptr_d      = vptr_q;
        train_d     = train_q;
        valid_d     = valid_q;
        epoch_d     = epoch_q;
        lr_d        = lr_q;
        out_valid_d = 1'b0;
        is_train_d  = is_train_q;
        vl_drop_d   = 1'b0;
        tr_acc      = 1'b0;
        vl_acc      = 1'b0;
        epoch_end   = 1'b0;
        rd_en       = 1'b0;
        rd_addr     = '0;

        tsum = {1'b0, tptr_q} + {1'b0, offset};
        if (32'(tsum) >= NTRAIN) tsum = tsum - (TW+1)'(NTRAIN);

        if (sw) begin
            // Restart wins over any request in the same cycle
            state_d = S_RUN;
            tptr_d  = '0;
            vptr_d  = '0;
            train_d = '0;
            valid_d = '0;
            epoch_d = '0;
            lr_d    = LR_INIT;
        end else begin
            tr_acc    = tr && (state_q == S_RUN);
            vl_acc    = vl && !tr_acc && (state_q != S_IDLE);
            vl_drop_d = tr_acc && vl;

            if (tr_acc) begin
                rd_en       = 1'b1;
                rd_addr     = AW'(tsum);
                out_valid_d = 1'b1;
                is_train_d  = 1'b1;
                if (tptr_q == TW'(NTRAIN - 1)) begin
                    epoch_end = 1'b1;
                    tptr_d    = '0;
                    train_d   = '0;
                    epoch_d   = epoch_inc;
                    lr_d      = BITS'(lr_decay(32'(lr_q), LR_SHIFT, 32'(LR_MIN)));
                    if (epoch_inc == BITS'(EPOCH_MAX)) state_d = S_DONE;
                end else begin
                    tptr_d  = tptr_q + TW'(1);
                    train_d = train_q + BITS'(1);
                end
            end else if (vl_acc) begin
                rd_en       = 1'b1;
                rd_addr     = AW'(NTRAIN) + AW'(vptr_q);
                out_valid_d = 1'b1;
                is_train_d  = 1'b0;
                vptr_d      = (vptr_q == VW'(NVALID - 1)) ? '0 : vptr_q + VW'(1);
                if (valid_q != '1) valid_d = valid_q + BITS'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            tptr_q      <= '0;
            vptr_q      <= '0;
            train_q     <= '0;
            valid_q     <= '0;
            epoch_q     <= '0;
            lr_q        <= LR_INIT;
            out_valid_q <= 1'b0;
            is_train_q  <= 1'b0;
            vl_drop_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            tptr_q      <= tptr_d;
            vptr_q      <= vptr_d;
            train_q     <= train_d;
            valid_q     <= valid_d;
            epoch_q     <= epoch_d;
            lr_q        <= lr_d;
            out_valid_q <= out_valid_d;
            is_train_q  <= is_train_d;
            vl_drop_q   <= vl_drop_d;
        end
    end

    pattern_mem #(
        .DEPTH(NTRAIN + NVALID),
        .WIDTH(MW),
        .AW   (AW)
    ) u_mem (
        .clk    (clk),
        .rst_n  (rst_n),
        .wr_en  (ld_en),
        .wr_addr(ld_addr),
        .wr_data({ld_y, ld_x}),
        .rd_en  (rd_en),
        .rd_addr(rd_addr),
        .rd_data(rd_data)
    );

    assign x         = rd_data[NX*BITS-1:0];
    assign y         = rd_data[NX*BITS +: BITS];
    assign out_valid = out_valid_q;
    assign is_train  = is_train_q;
    assign vl_drop   = vl_drop_q;
    assign lr        = lr_q;
    assign TRAIN     = train_q;
    assign VALID     = valid_q;
    assign EPOCH     = epoch_q;
    assign done      = (state_q == S_DONE);

endmodule

// File: tb/tb_pattern_sequencer.sv
// Directed bench for pattern_sequencer: NTRAIN=4, NVALID=3, EPOCH_MAX=2, sample k has y=k.
module tb_pattern_sequencer;

    localparam int unsigned NX = 4;
    localparam int unsigned BITS = 16;
`ifdef PATTERN_SHUFFLE_EN
    localparam int ROT = 1;  // SEED 16'hACE1 low two bits
`else
    localparam int ROT = 0;
`endif

    logic          clk = 1'b0;
    logic          rst_n, sw, tr, vl, ld_en;
    logic [2:0]    ld_addr;
    logic [63:0]   ld_x, x;
    logic [15:0]   ld_y, y, lr, train, valid, epoch;
    logic          out_valid, is_train, vl_drop, done;

    int n_vec  = 0;
    int n_miss = 0;

    always #5 clk = ~clk;

    pattern_sequencer #(
        .NX(NX), .BITS(BITS), .NTRAIN(4), .NVALID(3), .EPOCH_MAX(2),
        .LR_INIT(16'h1000), .LR_SHIFT(3), .LR_MIN(16'h0040), .SEED(16'hACE1)
    ) dut (
        .clk(clk), .rst_n(rst_n), .sw(sw), .tr(tr), .vl(vl),
        .ld_en(ld_en), .ld_addr(ld_addr), .ld_x(ld_x), .ld_y(ld_y),
        .x(x), .y(y), .out_valid(out_valid), .is_train(is_train), .vl_drop(vl_drop),
        .lr(lr), .TRAIN(train), .VALID(valid), .EPOCH(epoch), .done(done)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] xpat(input int k);
        xpat = {16'hD000 + 16'(k), 16'hC000 + 16'(k), 16'hB000 + 16'(k), 16'hA000 + 16'(k)};
    endfunction

    task automatic check_reset(input string tag);
        check({tag, "_ov"}, out_valid, 0);
        check({tag, "_x"}, x, 0);
        check({tag, "_y"}, y, 0);
        check({tag, "_it"}, is_train, 0);
        check({tag, "_drop"}, vl_drop, 0);
        check({tag, "_train"}, train, 0);
        check({tag, "_valid"}, valid, 0);
        check({tag, "_epoch"}, epoch, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_lr"}, lr, 16'h1000);
    endtask

    initial begin
        rst_n = 1'b0; sw = 0; tr = 0; vl = 0;
        ld_en = 0; ld_addr = '0; ld_x = '0; ld_y = '0;
        repeat (2) @(posedge clk);
        #1;
        check_reset("rst");
        rst_n = 1'b1;

        for (int k = 0; k < 7; k++) begin
            ld_en = 1; ld_addr = 3'(k); ld_x = xpat(k); ld_y = 16'(k);
            tick();
        end
        ld_en = 0;

        // Requests in IDLE are ignored
        tr = 1; tick();
        check("idle_ov", out_valid, 0);
        check("idle_train", train, 0);

        // Request coincident with sw is dropped
        sw = 1; tick(); sw = 0;
        check("sw_drop_ov", out_valid, 0);

        for (int k = 0; k < 4; k++) begin
            tick();
            check("e1_ov", out_valid, 1);
            check("e1_y", y, 64'(k));
            check("e1_it", is_train, 1);
            check("e1_train", train, 64'((k + 1) % 4));
            if (k == 0) check("e1_x", x, xpat(0));
            if (k == 2) begin
                check("e1_lr_mid", lr, 16'h1000);
                check("e1_epoch_mid", epoch, 0);
            end
        end
        check("e1_epoch", epoch, 1);
        check("e1_lr", lr, 16'h0E00);
        check("e1_done", done, 0);

        // tr+vl collision: training wins, vl dropped
        vl = 1; tick(); vl = 0;
        check("col_ov", out_valid, 1);
        check("col_y", y, 64'(ROT % 4));
        check("col_it", is_train, 1);
        check("col_drop", vl_drop, 1);
        check("col_valid", valid, 0);
        check("col_train", train, 1);

        for (int k = 1; k < 4; k++) begin
            tick();
            check("e2_y", y, 64'((k + ROT) % 4));
            check("e2_train", train, 64'((k + 1) % 4));
            if (k == 2) check("e2_done_mid", done, 0);
        end
        check("e2_ov", out_valid, 1);
        check("e2_done", done, 1);
        check("e2_epoch", epoch, 2);
        check("e2_lr", lr, 16'h0C40);
        check("e2_drop", vl_drop, 0);

        // tr ignored in DONE
        tick(); tr = 0;
        check("dn_ov", out_valid, 0);
        check("dn_train", train, 0);
        check("dn_epoch", epoch, 2);
        check("dn_lr", lr, 16'h0C40);
        check("dn_y_hold", y, 64'((3 + ROT) % 4));

        vl = 1;
        for (int k = 0; k < 4; k++) begin
            tick();
            check("v_ov", out_valid, 1);
            check("v_y", y, 64'(4 + (k % 3)));
            check("v_it", is_train, 0);
            check("v_valid", valid, 64'(k + 1));
            check("v_done", done, 1);
        end
        tr = 1; tick(); tr = 0; vl = 0;
        check("dv_y", y, 5);
        check("dv_it", is_train, 0);
        check("dv_drop", vl_drop, 0);
        check("dv_valid", valid, 5);

        sw = 1; tick(); sw = 0;
        check("rs_lr", lr, 16'h1000);
        check("rs_epoch", epoch, 0);
        check("rs_valid", valid, 0);
        check("rs_done", done, 0);
        check("rs_ov", out_valid, 0);

        // Write and read of address 0 in the same cycle returns old data
        tr = 1; ld_en = 1; ld_addr = 3'd0; ld_y = 16'h0055; ld_x = '0;
        tick(); ld_en = 0;
        check("rw_y_old", y, 0);
        check("rw_x_old", x, xpat(0));
        tick();
        check("bb_y", y, 1);
        check("bb_train", train, 2);

        // Asynchronous reset mid-burst
        #1 rst_n = 1'b0;
        #1 check_reset("arst");
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;
        tick();
        check("post_rst_ov0", out_valid, 0);
        tick();
        check("post_rst_ov1", out_valid, 0);
        sw = 1; tick(); sw = 0;
        check("post_sw_ov", out_valid, 0);
        tick(); tr = 0;
        check("new_ov", out_valid, 1);
        check("new_y", y, 16'h0055);
        check("new_x", x, 0);
        tick();
        check("hold_ov", out_valid, 0);
        check("hold_y", y, 16'h0055);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
